// File: rtl/ext_arb_pkg.sv
// rtl/ext_arb_pkg.sv - shared constants for the external bus arbiter
// Purpose: FSM state encoding, port index constants, statistics counter
//          width and a saturating increment helper used by ext_bus_arbiter.
// Ports:   none (package).
package ext_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ext_arb_rr.sv
// rtl/ext_arb_rr.sv - combinational two-way round-robin pick
// Purpose: chooses between port A and port B; on a conflict the port that
//          did not hold the last grant wins.
// Ports:   req_a_i, req_b_i - request levels
//          last_i           - previous grant (PORT_A / PORT_B)
//          grant_o          - chosen port, meaningful when valid_o is high
//          valid_o          - at least one request present
module ext_arb_rr
    import ext_arb_pkg::*;
(
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic last_i,
    output logic grant_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req_a_i | req_b_i;
        if (req_a_i && req_b_i) begin
            grant_o = ~last_i;
        end else if (req_b_i) begin
            grant_o = PORT_B;
        end else begin
            grant_o = PORT_A;
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// rtl/ext_bus_arbiter.sv - two-port round-robin arbiter onto one external register bus
// Purpose: shares a fixed-read-latency ext register port between port A (host)
//          and port B (local sequencer); one transaction in flight, per-port
//          read data registers and one-cycle ack pulses.
// Ports:   clk, rst (sync, active high)
//          a_req/a_we/a_addr/a_wdata -> a_ack/a_rdata  : port A
//          b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata  : port B
//          busy, owner                                  : status
//          ext_addr/ext_wdata/ext_we -> ext_rdata       : external module
// Option:  EXT_BUS_ARBITER_STATS_EN adds a_grant_cnt, b_grant_cnt, conflict_cnt.
module ext_bus_arbiter
    import ext_arb_pkg::*;
#(
    parameter int AW     = 2,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic          owner,
    output logic [AW-1:0] ext_addr,
    output logic [DW-1:0] ext_wdata,
    output logic          ext_we,
    input  logic [DW-1:0] ext_rdata
`ifdef EXT_BUS_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] a_grant_cnt,
    output logic [STAT_W-1:0] b_grant_cnt,
    output logic [STAT_W-1:0] conflict_cnt
`endif
);

    // WAIT is entered with RD_LAT-1 so capture lands RD_LAT cycles after ISSUE
    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    logic [1:0]    state_q,   state_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic          owner_q,   owner_d;
    logic          we_q,      we_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    logic grant;
    logic grant_valid;

    ext_arb_rr u_rr (
        .req_a_i (a_req),
        .req_b_i (b_req),
        .last_i  (owner_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            owner_q   <= PORT_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant;
                    we_d    = (grant == PORT_B) ? b_we    : a_we;
                    addr_d  = (grant == PORT_B) ? b_addr  : a_addr;
                    wdata_d = (grant == PORT_B) ? b_wdata : a_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    if (owner_q == PORT_B) begin
                        b_rdata_d = ext_rdata;
                    end else begin
                        a_rdata_d = ext_rdata;
                    end
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != IDLE);
        owner     = owner_q;
        ext_we    = (state_q == ISSUE) && we_q;
        ext_addr  = addr_q;
        ext_wdata = wdata_q;
        a_ack     = (state_q == DONE) && (owner_q == PORT_A);
        b_ack     = (state_q == DONE) && (owner_q == PORT_B);
        a_rdata   = a_rdata_q;
        b_rdata   = b_rdata_q;
    end

`ifdef EXT_BUS_ARBITER_STATS_EN
    logic [STAT_W-1:0] a_grant_cnt_q;
    logic [STAT_W-1:0] b_grant_cnt_q;
    logic [STAT_W-1:0] conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_grant_cnt_q  <= '0;
            b_grant_cnt_q  <= '0;
            conflict_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (grant_valid && (grant == PORT_A)) begin
                a_grant_cnt_q <= sat_inc(a_grant_cnt_q);
            end
            if (grant_valid && (grant == PORT_B)) begin
                b_grant_cnt_q <= sat_inc(b_grant_cnt_q);
            end
            if (a_req && b_req) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
        end
    end

    assign a_grant_cnt  = a_grant_cnt_q;
    assign b_grant_cnt  = b_grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb/tb_ext_bus_arbiter.sv - self-checking bench for ext_bus_arbiter
module tb_ext_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, busy, owner, ext_we;
    logic [7:0] a_rdata, b_rdata, ext_wdata, ext_rdata;
    logic [1:0] ext_addr;

    logic       rst3;
    logic       a_req3, a_we3, b_req3, b_we3;
    logic [1:0] a_addr3, b_addr3;
    logic [7:0] a_wdata3, b_wdata3;
    logic       a_ack3, b_ack3, busy3, owner3, ext_we3;
    logic [7:0] a_rdata3, b_rdata3, ext_wdata3, ext_rdata3;
    logic [1:0] ext_addr3;

`ifdef EXT_BUS_ARBITER_STATS_EN
    logic [15:0] a_gc, b_gc, c_gc, a_gc3, b_gc3, c_gc3;
`endif

    int n_chk;
    int n_fail;

    // reference model state
    logic [7:0] ref_mem [4];
    logic [7:0] m_a_rd, m_b_rd;
    logic       m_owner;
    int         m_agr, m_bgr, m_conf;
    logic       pa, pb;

    // external module for the RD_LAT=1 instance
    logic [7:0] mem [4];
    assign ext_rdata = mem[ext_addr];
    always @(posedge clk) begin
        if (ext_we) mem[ext_addr] <= ext_wdata;
    end

    ext_bus_arbiter #(.AW(2), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .owner(owner),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we),
        .ext_rdata(ext_rdata)
`ifdef EXT_BUS_ARBITER_STATS_EN
        , .a_grant_cnt(a_gc), .b_grant_cnt(b_gc), .conflict_cnt(c_gc)
`endif
    );

    ext_bus_arbiter #(.AW(2), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3),
        .a_req(a_req3), .a_we(a_we3), .a_addr(a_addr3), .a_wdata(a_wdata3),
        .a_ack(a_ack3), .a_rdata(a_rdata3),
        .b_req(b_req3), .b_we(b_we3), .b_addr(b_addr3), .b_wdata(b_wdata3),
        .b_ack(b_ack3), .b_rdata(b_rdata3),
        .busy(busy3), .owner(owner3),
        .ext_addr(ext_addr3), .ext_wdata(ext_wdata3), .ext_we(ext_we3),
        .ext_rdata(ext_rdata3)
`ifdef EXT_BUS_ARBITER_STATS_EN
        , .a_grant_cnt(a_gc3), .b_grant_cnt(b_gc3), .conflict_cnt(c_gc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One arbitration decision and its full transaction, entered at #1 in an
    // IDLE cycle with the requests already driven; leaves at #1 in IDLE.
    task automatic run_txn();
        logic       wp;
        logic       w;
        logic [1:0] ad;
        logic [7:0] wd;
        int         lat;
        if (pa && pb) begin
            wp = ~m_owner;
            m_conf++;
        end else begin
            wp = pb;
        end
        m_owner = wp;
        if (wp) m_bgr++; else m_agr++;
        w   = wp ? b_we    : a_we;
        ad  = wp ? b_addr  : a_addr;
        wd  = wp ? b_wdata : a_wdata;
        lat = w ? 2 : 3;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                n_chk++;
                if (ext_we !== w) begin
                    n_fail++; $display("FAIL issue_we: got %0b want %0b", ext_we, w);
                end
                n_chk++;
                if (ext_addr !== ad) begin
                    n_fail++; $display("FAIL issue_addr: got %0h want %0h", ext_addr, ad);
                end
                n_chk++;
                if (w && ext_wdata !== wd) begin
                    n_fail++; $display("FAIL issue_wdata: got %0h want %0h", ext_wdata, wd);
                end
                n_chk++;
                if (owner !== wp || busy !== 1'b1) begin
                    n_fail++; $display("FAIL grant: owner %0b busy %0b want owner %0b busy 1", owner, busy, wp);
                end
            end else begin
                n_chk++;
                if (ext_we !== 1'b0) begin
                    n_fail++; $display("FAIL we_extra: got %0b want 0 at k=%0d", ext_we, k);
                end
            end
            if (k == lat) begin
                if (w) ref_mem[ad] = wd;
                else if (wp) m_b_rd = ref_mem[ad];
                else m_a_rd = ref_mem[ad];
            end
            n_chk++;
            if (a_ack !== (k == lat && !wp) || b_ack !== (k == lat && wp)) begin
                n_fail++;
                $display("FAIL ack: k=%0d got a=%0b b=%0b want a=%0b b=%0b", k, a_ack, b_ack,
                         (k == lat && !wp), (k == lat && wp));
            end
            if (k == lat) begin
                n_chk++;
                if (a_rdata !== m_a_rd || b_rdata !== m_b_rd) begin
                    n_fail++;
                    $display("FAIL rdata: got a=%0h b=%0h want a=%0h b=%0h", a_rdata, b_rdata, m_a_rd, m_b_rd);
                end
                if (wp) begin b_req = 1'b0; pb = 1'b0; end
                else    begin a_req = 1'b0; pa = 1'b0; end
            end
        end
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
            n_fail++; $display("FAIL post_idle: busy %0b a_ack %0b b_ack %0b want 0", busy, a_ack, b_ack);
        end
    endtask

    task automatic drive_a(input logic we, input logic [1:0] ad, input logic [7:0] wd);
        a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; pa = 1'b1;
    endtask

    task automatic drive_b(input logic we, input logic [1:0] ad, input logic [7:0] wd);
        b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; pb = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || owner !== 1'b1 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy %0b owner %0b acks %0b%0b want 0 1 00", busy, owner, a_ack, b_ack);
        end
        n_chk++;
        if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %0h %0h want 0 0", a_rdata, b_rdata);
        end
        n_chk++;
        if (ext_we !== 1'b0 || ext_addr !== 2'd0 || ext_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_bus: we %0b addr %0h wdata %0h want 0 0 0", ext_we, ext_addr, ext_wdata);
        end
        rst = 1'b0; rst3 = 1'b0;
        m_owner = 1'b1; m_a_rd = 8'h00; m_b_rd = 8'h00;
    endtask

    task automatic test_a_write();
        drive_a(1'b1, 2'h1, 8'h5a);
        run_txn();
    endtask

    task automatic test_b_read();
        mem[2] = 8'hc3; ref_mem[2] = 8'hc3;
        drive_b(1'b0, 2'h2, 8'h00);
        run_txn();
    endtask

    task automatic test_alternate();
        logic exp_order [4];
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        for (int r = 0; r < 5; r++) begin
            drive_a(1'b1, 2'(r), 8'(8'h10 + r));
            drive_b(1'b0, 2'(r + 1), 8'h00);
            for (int g = 0; g < 2; g++) begin
                run_txn();
                if (r < 2) begin
                    n_chk++;
                    if (owner !== exp_order[r * 2 + g]) begin
                        n_fail++; $display("FAIL alt_order: grant %0d owner %0b want %0b", r * 2 + g, owner, exp_order[r * 2 + g]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 1) == 1) drive_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 1) == 1) drive_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            if (!pa && !pb) begin
                @(posedge clk); #1;
                n_chk++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL idle_busy: got %0b want 0", busy);
                end
            end
            while (pa || pb) run_txn();
        end
    endtask

    task automatic test_read_lat3();
        a_req3 = 1'b1; a_we3 = 1'b0; a_addr3 = 2'h3;
        ext_rdata3 = 8'hee;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            ext_rdata3 = (k == 3) ? 8'h11 : (k == 4) ? 8'h77 : 8'hee;
            n_chk++;
            if (a_ack3 !== (k == 5) || b_ack3 !== 1'b0) begin
                n_fail++; $display("FAIL lat3_ack: k=%0d got a=%0b b=%0b want a=%0b b=0", k, a_ack3, b_ack3, (k == 5));
            end
            if (k == 5) begin
                a_req3 = 1'b0;
                n_chk++;
                if (a_rdata3 !== 8'h77) begin
                    n_fail++; $display("FAIL lat3_rdata: got %0h want 77", a_rdata3);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        a_req3 = 1'b1; a_we3 = 1'b0; a_addr3 = 2'h1;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b1; a_req3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (busy3 !== 1'b0 || ext_we3 !== 1'b0 || a_ack3 !== 1'b0 || b_ack3 !== 1'b0) begin
                n_fail++; $display("FAIL rst_wait: k=%0d busy %0b we %0b acks %0b%0b want all 0", k, busy3, ext_we3, a_ack3, b_ack3);
            end
            @(posedge clk); #1;
        end
        a_req3 = 1'b1; a_we3 = 1'b1; a_addr3 = 2'h0; a_wdata3 = 8'h3c;
        @(posedge clk); #1;
        n_chk++;
        if (ext_we3 !== 1'b1 || ext_addr3 !== 2'h0 || ext_wdata3 !== 8'h3c) begin
            n_fail++; $display("FAIL rst_wr_issue: we %0b addr %0h data %0h want 1 0 3c", ext_we3, ext_addr3, ext_wdata3);
        end
        @(posedge clk); #1;
        a_req3 = 1'b0;
        n_chk++;
        if (a_ack3 !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_ack: got %0b want 1", a_ack3);
        end
    endtask

`ifdef EXT_BUS_ARBITER_STATS_EN
    task automatic test_stats();
        n_chk++;
        if (a_gc !== 16'(m_agr) || b_gc !== 16'(m_bgr) || c_gc !== 16'(m_conf)) begin
            n_fail++; $display("FAIL stats: got %0d %0d %0d want %0d %0d %0d", a_gc, b_gc, c_gc, m_agr, m_bgr, m_conf);
        end
    endtask
`endif

    initial begin
        n_chk = 0; n_fail = 0;
        m_agr = 0; m_bgr = 0; m_conf = 0;
        pa = 1'b0; pb = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        a_req3 = 0; a_we3 = 0; a_addr3 = 0; a_wdata3 = 0;
        b_req3 = 0; b_we3 = 0; b_addr3 = 0; b_wdata3 = 0;
        ext_rdata3 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem[i] = 8'(8'h40 + i);
            ref_mem[i] = 8'(8'h40 + i);
        end
        test_reset();
        test_a_write();
        test_b_read();
`ifdef EXT_BUS_ARBITER_STATS_EN
        test_stats();
`endif
        test_reset();
        m_agr = 0; m_bgr = 0; m_conf = 0;
        test_alternate();
`ifdef EXT_BUS_ARBITER_STATS_EN
        test_stats();
`endif
        test_random();
`ifdef EXT_BUS_ARBITER_STATS_EN
        test_stats();
`endif
        test_read_lat3();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
